// File: rtl/snake_seq_pkg.sv
// Shared types and constants for the snake game sequencer.
package snake_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_MOVE  = 3'd2,
        S_CHECK = 3'd3,
        S_GROW  = 3'd4,
        S_DRAW  = 3'd5,
        S_OVER  = 3'd6
    } state_t;

    // Default number of cycles DRAW waits for the renderer before giving up.
    localparam int DRAW_TIMEOUT_DEF = 255;

    // Frame ticks per move after reset, before any speed is latched.
    localparam logic [3:0] DIV_RESET = 4'd8;

    // Movement rate select to frame ticks per move.
    function automatic logic [3:0] speed_to_div(input logic [1:0] sel);
        case (sel)
            2'd0:    return 4'd8;
            2'd1:    return 4'd6;
            2'd2:    return 4'd4;
            default: return 4'd2;
        endcase
    endfunction

endpackage

// File: rtl/game_sequencer_pb_edge.sv
// Push-button rising-edge detector: registers the level and emits a
// one-cycle pulse when it goes from low to high. A held button gives one pulse.
module pb_edge (
    input  logic clk,
    input  logic nrst,
    input  logic pb_i,
    output logic rise_o
);

    logic pb_q;
    logic pb_d;

    // History of the button level for edge comparison.
    always_comb begin
        pb_d = pb_i;
    end

    // History register; cleared on reset so a button held through reset
    // still produces an edge once reset is released.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pb_q <= 1'b0;
        end else begin
            pb_q <= pb_d;
        end
    end

    assign rise_o = pb_i & ~pb_q;

endmodule

// File: rtl/game_sequencer.sv
// Game sequencer: Moore FSM pacing movement, collision sampling, apple
// respawn and rendering of the snake game, with pause and draw watchdog.
module game_sequencer
    import snake_seq_pkg::*;
#(
    parameter int DRAW_TIMEOUT = DRAW_TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       start_pb,
    input  logic       pause_pb,
    input  logic [1:0] speed_sel,
    input  logic       frame_tick,
    input  logic       good_coll,
    input  logic       bad_coll,
    input  logic       game_complete,
    input  logic       draw_done,
    output logic       sync_reset,
    output logic       move_en,
    output logic       coll_sample,
    output logic       apple_respawn,
    output logic       draw_start,
    output logic       game_over,
    output logic       paused,
    output logic       draw_timeout,
    output logic [2:0] state_o
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(DRAW_TIMEOUT - 1);

    state_t     state_q,        state_d;
    logic [3:0] frame_cnt_q,    frame_cnt_d;
    logic [3:0] div_q,          div_d;
    logic [7:0] wait_cnt_q,     wait_cnt_d;
    logic       paused_q,       paused_d;
    logic       draw_timeout_q, draw_timeout_d;
    logic       sync_reset_q,   sync_reset_d;

    logic       start_rise;
    logic       pause_rise;

    pb_edge u_start_edge (
        .clk    (clk),
        .nrst   (nrst),
        .pb_i   (start_pb),
        .rise_o (start_rise)
    );

    pb_edge u_pause_edge (
        .clk    (clk),
        .nrst   (nrst),
        .pb_i   (pause_pb),
        .rise_o (pause_rise)
    );

    // Next-state and next-value logic for the sequencer.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d        = state_q;
        frame_cnt_d    = frame_cnt_q;
        div_d          = div_q;
        wait_cnt_d     = '0;
        paused_d       = paused_q;
        draw_timeout_d = draw_timeout_q;
        sync_reset_d   = 1'b0;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_rise) begin
                    state_d        = S_WAIT;
                    sync_reset_d   = 1'b1;
                    frame_cnt_d    = '0;
                    paused_d       = 1'b0;
                    draw_timeout_d = 1'b0;
                    div_d          = speed_to_div(speed_sel);
                end
            end
            S_WAIT: begin
                if (pause_rise) begin
                    paused_d = ~paused_q;
                end
                // Ticks are judged against the pause state held this cycle.
                if (!paused_q && frame_tick) begin
                    if (frame_cnt_q == div_q - 4'd1) begin
                        frame_cnt_d = '0;
                        state_d     = S_MOVE;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 4'd1;
                    end
                end
            end
            S_MOVE: begin
                div_d   = speed_to_div(speed_sel);
                state_d = S_CHECK;
            end
            S_CHECK: begin
                // A fatal collision or a finished game outranks growth.
                if (bad_coll || game_complete) begin
                    state_d = S_OVER;
                end else if (good_coll) begin
                    state_d = S_GROW;
                end else begin
                    state_d = S_DRAW;
                end
            end
            S_GROW: begin
                state_d = S_DRAW;
            end
            S_DRAW: begin
                if (draw_done) begin
                    state_d = S_WAIT;
                end else if (wait_cnt_q == TIMEOUT_LAST) begin
                    draw_timeout_d = 1'b1;
                    state_d        = S_WAIT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q        <= S_IDLE;
            frame_cnt_q    <= '0;
            div_q          <= DIV_RESET;
            wait_cnt_q     <= '0;
            paused_q       <= 1'b0;
            draw_timeout_q <= 1'b0;
            sync_reset_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state_q        <= state_d;
            frame_cnt_q    <= frame_cnt_d;
            div_q          <= div_d;
            wait_cnt_q     <= wait_cnt_d;
            paused_q       <= paused_d;
            draw_timeout_q <= draw_timeout_d;
            sync_reset_q   <= sync_reset_d;
        end
    end

    // Moore outputs decoded from registers only; the DRAW counter is zero
    // exactly on the entry cycle, which marks draw_start.
    assign sync_reset    = sync_reset_q;
    assign move_en       = (state_q == S_MOVE);
    assign coll_sample   = (state_q == S_CHECK);
    assign apple_respawn = (state_q == S_GROW);
    assign draw_start    = (state_q == S_DRAW) && (wait_cnt_q == 8'd0);
    assign game_over     = (state_q == S_OVER);
    assign paused        = paused_q;
    assign draw_timeout  = draw_timeout_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed testbench for game_sequencer.
module tb_game_sequencer;

    logic       clk = 1'b0;
    logic       nrst;
    logic       start_pb, pause_pb, frame_tick;
    logic       good_coll, bad_coll, game_complete, draw_done;
    logic [1:0] speed_sel;
    logic       sync_reset, move_en, coll_sample, apple_respawn, draw_start;
    logic       game_over, paused, draw_timeout;
    logic [2:0] state_o;

    int n_tests = 0;
    int n_fail  = 0;
    int n_sync = 0, n_move = 0, n_coll = 0, n_apple = 0, n_draw = 0, n_multi = 0;

    game_sequencer dut (
        .clk           (clk),
        .nrst          (nrst),
        .start_pb      (start_pb),
        .pause_pb      (pause_pb),
        .speed_sel     (speed_sel),
        .frame_tick    (frame_tick),
        .good_coll     (good_coll),
        .bad_coll      (bad_coll),
        .game_complete (game_complete),
        .draw_done     (draw_done),
        .sync_reset    (sync_reset),
        .move_en       (move_en),
        .coll_sample   (coll_sample),
        .apple_respawn (apple_respawn),
        .draw_start    (draw_start),
        .game_over     (game_over),
        .paused        (paused),
        .draw_timeout  (draw_timeout),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    // Strobe counters, sampled mid-cycle.
    always @(negedge clk) begin
        n_sync  += int'(sync_reset);
        n_move  += int'(move_en);
        n_coll  += int'(coll_sample);
        n_apple += int'(apple_respawn);
        n_draw  += int'(draw_start);
        if ($countones({sync_reset, move_en, coll_sample, apple_respawn, draw_start}) > 1)
            n_multi++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance one cycle; sample and drive just after the falling edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
    endtask

    function automatic logic [4:0] strobes();
        return {sync_reset, move_en, coll_sample, apple_respawn, draw_start};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int mv;
        int n;
        nrst = 1'b0; start_pb = 0; pause_pb = 0; frame_tick = 0;
        good_coll = 0; bad_coll = 0; game_complete = 0; draw_done = 0;
        speed_sel = 2'd2;
        cyc(2);
        check("rst_state", 32'(state_o), 0);
        check("rst_strobes", 32'(strobes()), 0);
        check("rst_levels", 32'({game_over, paused, draw_timeout}), 0);
        nrst = 1'b1;
        cyc(1);

        // Start: held button gives one sync_reset, WAIT.
        start_pb = 1'b1;
        cyc(1);
        check("start_sync", 32'(sync_reset), 1);
        check("start_state", 32'(state_o), 1);
        cyc(4);
        start_pb = 1'b0;
        check("start_sync_count", 32'(n_sync), 1);
        check("start_state_hold", 32'(state_o), 1);

        // Cadence with div=4: moves on ticks 4 and 8.
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i % 4 == 0) begin
                check("cad_move", 32'(move_en), 1);
                cyc(1);
                check("cad_coll", 32'(coll_sample), 1);
                cyc(1);
                check("cad_draw", 32'({draw_start, state_o}), 32'({1'b1, 3'd5}));
                draw_done = 1'b1;
                cyc(1);
                draw_done = 1'b0;
                check("cad_back_wait", 32'(state_o), 1);
            end else begin
                check("cad_wait", 32'({move_en, state_o}), 32'({1'b0, 3'd1}));
            end
        end
        check("cad_move_count", 32'(n_move), 2);
        check("cad_coll_count", 32'(n_coll), 2);
        check("cad_draw_count", 32'(n_draw), 2);

        // Arbitration: both collisions high, bad wins. speed_sel latched at MOVE.
        speed_sel = 2'd3;
        repeat (4) tick();
        check("arb_move_state", 32'(state_o), 2);
        good_coll = 1'b1;
        bad_coll  = 1'b1;
        cyc(1);
        check("arb_check_state", 32'(state_o), 3);
        cyc(1);
        check("arb_over", 32'({game_over, state_o}), 32'({1'b1, 3'd6}));
        check("arb_no_apple", 32'(n_apple), 0);
        mv = n_move;
        frame_tick = 1'b1;
        cyc(3);
        frame_tick = 1'b0;
        check("over_hold", 32'(state_o), 6);
        check("over_strobes", 32'(strobes()), 0);
        check("over_no_move", 32'(n_move), 32'(mv));
        good_coll = 1'b0;
        bad_coll  = 1'b0;

        // Restart from OVER; div now 2.
        start_pb = 1'b1;
        cyc(1);
        start_pb = 1'b0;
        check("restart", 32'({sync_reset, game_over, state_o}), 32'({1'b1, 1'b0, 3'd1}));

        // Growth path.
        tick();
        check("grow_tick1", 32'(state_o), 1);
        tick();
        check("grow_move", 32'(move_en), 1);
        good_coll = 1'b1;
        cyc(1);
        check("grow_coll", 32'(coll_sample), 1);
        cyc(1);
        check("grow_apple", 32'({apple_respawn, state_o}), 32'({1'b1, 3'd4}));
        good_coll = 1'b0;
        cyc(1);
        check("grow_draw_start", 32'({draw_start, state_o}), 32'({1'b1, 3'd5}));
        cyc(2);
        check("grow_draw_hold", 32'({draw_start, state_o}), 32'({1'b0, 3'd5}));
        draw_done = 1'b1;
        cyc(1);
        draw_done = 1'b0;
        check("grow_back_wait", 32'(state_o), 1);
        check("grow_apple_count", 32'(n_apple), 1);

        // Pause: frame_cnt holds at 1 while ticks are ignored.
        tick();
        pause_pb = 1'b1;
        cyc(1);
        check("pause_on", 32'(paused), 1);
        cyc(3);
        pause_pb = 1'b0;
        check("pause_held_once", 32'(paused), 1);
        mv = n_move;
        repeat (10) tick();
        check("pause_no_move", 32'(n_move), 32'(mv));
        check("pause_state", 32'(state_o), 1);
        pause_pb = 1'b1;
        cyc(1);
        pause_pb = 1'b0;
        check("pause_off", 32'(paused), 0);
        tick();
        check("pause_cnt_held", 32'(move_en), 1);

        // Draw timeout; pause edges in DRAW are ignored.
        cyc(2);
        check("to_draw", 32'(state_o), 5);
        n = 0;
        while (state_o == 3'd5 && n < 300) begin
            if (n == 10) pause_pb = 1'b1;
            if (n == 12) pause_pb = 1'b0;
            n++;
            cyc(1);
        end
        check("to_draw_cycles", 32'(n), 255);
        check("to_result", 32'({draw_timeout, state_o}), 32'({1'b1, 3'd1}));
        check("to_pause_ignored", 32'(paused), 0);

        // Timeout flag is sticky across a normal draw.
        repeat (2) tick();
        cyc(2);
        draw_done = 1'b1;
        cyc(1);
        draw_done = 1'b0;
        check("to_sticky", 32'({draw_timeout, state_o}), 32'({1'b1, 3'd1}));

        // Asynchronous reset mid-DRAW, then start held through release.
        repeat (2) tick();
        cyc(2);
        check("rmid_draw", 32'(state_o), 5);
        #2 nrst = 1'b0;
        #1;
        check("rmid_state", 32'(state_o), 0);
        check("rmid_outputs", 32'({strobes(), game_over, paused, draw_timeout}), 0);
        start_pb = 1'b1;
        cyc(2);
        nrst = 1'b1;
        #1;
        check("rmid_release_quiet", 32'({strobes(), state_o}), 0);
        cyc(1);
        check("rmid_first_start", 32'({sync_reset, state_o}), 32'({1'b1, 3'd1}));
        start_pb = 1'b0;
        cyc(2);

        check("strobe_onehot", 32'(n_multi), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter DRAW_TIMEOUT, default 255, the maximum number of cycles DRAW waits for draw_done.
REQ-002 SHALL have port clk, input, 1: single system clock; all state updates on its rising edge.
REQ-003 SHALL have port nrst, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port start_pb, input, 1: start/restart button, already synchronised, level.
REQ-005 SHALL have port pause_pb, input, 1: pause button, already synchronised, level.
REQ-006 SHALL have port speed_sel, input, 2: movement rate select.
REQ-007 SHALL have port frame_tick, input, 1: one-cycle pulse per completed display frame.
REQ-008 SHALL have ports good_coll, bad_coll, game_complete, each input, 1: collision and score status, level.
REQ-009 SHALL have port draw_done, input, 1: renderer finished, one-cycle pulse.
REQ-010 SHALL have ports sync_reset, move_en, coll_sample, apple_respawn and draw_start, each output, 1: one-cycle strobes.
REQ-011 SHALL have port game_over, output, 1: level, high while in OVER.
REQ-012 SHALL have port paused, output, 1: level, high while paused.
REQ-013 SHALL have port draw_timeout, output, 1: sticky error flag.
REQ-014 SHALL have port state_o, output, 3: current state encoding.

Function
REQ-015 SHALL implement states IDLE=0, WAIT=1, MOVE=2, CHECK=3, GROW=4, DRAW=5, OVER=6 as a registered Moore machine.
REQ-016 SHALL detect start_pb and pause_pb rising edges internally; a held button SHALL yield exactly one event.
REQ-017 IDLE or OVER, on a start edge: SHALL pulse sync_reset for 1 cycle, clear frame_cnt and paused, latch speed_sel into div, and go to WAIT.
REQ-018 SHALL map div as speed_sel 0->8, 1->6, 2->4, 3->2 frame ticks per move.
REQ-019 WAIT: a pause edge SHALL toggle paused; while paused, frame_tick SHALL be ignored and frame_cnt SHALL hold.
REQ-020 WAIT, unpaused: each frame_tick SHALL increment the 4-bit frame_cnt; a tick arriving with frame_cnt==div-1 SHALL clear frame_cnt and go to MOVE.
REQ-021 Pause edges outside WAIT SHALL be ignored.
REQ-022 frame_tick arriving in any state other than WAIT SHALL be dropped, not queued.
REQ-023 MOVE SHALL last exactly 1 cycle with move_en=1, latch speed_sel into div, then go to CHECK.
REQ-024 CHECK SHALL last 1 cycle with coll_sample=1 and evaluate inputs that same cycle.
REQ-025 CHECK: if bad_coll or game_complete is high, SHALL go to OVER; else if good_coll, SHALL go to GROW; else SHALL go to DRAW.
REQ-026 CHECK: if bad_coll and good_coll are both high, bad_coll SHALL win.
REQ-027 GROW SHALL last 1 cycle with apple_respawn=1, then go to DRAW.
REQ-028 DRAW: draw_start SHALL be high on the entry cycle only.
REQ-029 DRAW: draw_done SHALL be honoured from the entry cycle onward and return the machine to WAIT.
REQ-030 DRAW: an 8-bit wait counter SHALL run; reaching DRAW_TIMEOUT without draw_done SHALL set draw_timeout and go to WAIT.
REQ-031 draw_timeout SHALL clear only on reset or sync_reset.
REQ-032 OVER: game_over=1; all strobes SHALL stay 0; only a start edge leaves OVER.
REQ-033 At most one strobe output SHALL be high in any cycle.
REQ-034 state_o SHALL equal the current state register.

Reset
REQ-035 On nrst low: state=IDLE, all strobes 0, game_over=0, paused=0, draw_timeout=0, frame_cnt=0, wait counter=0, div=8, edge-detector history=0.
REQ-036 Reset asserted mid-operation SHALL abort any state immediately, with no strobe emitted on release.
REQ-037 The first start edge after reset release SHALL be honoured.

Structure
REQ-038 The state enum, the speed-to-div table and the DRAW_TIMEOUT default SHALL live in shared package snake_seq_pkg.
REQ-039 SHALL instantiate sub-module pb_edge (register plus rising-edge pulse) once for each of start_pb and pause_pb.

Verification
REQ-040 Start test: reset; start_pb high 5 cycles -> sync_reset exactly 1 pulse, state_o=1.
REQ-041 Move cadence: speed_sel=2, 8 frame_ticks -> move_en exactly 2 pulses, each followed next cycle by coll_sample, then draw_start.
REQ-042 Collision arbitration: good_coll=1 and bad_coll=1 during CHECK -> state_o=6, game_over=1, no apple_respawn.
REQ-043 Growth path: good_coll=1 only -> apple_respawn 1 cycle, then draw_start; draw_done after 3 cycles -> state_o=1.
REQ-044 Pause and timeout: pause edge in WAIT, 10 frame_ticks -> no move_en; draw_done withheld 255 cycles -> draw_timeout=1, state_o=1.
REQ-045 Reset mid-DRAW: nrst low -> state_o=0 and all outputs 0 asynchronously.
